// File: rtl/linear_layer_start_token_dispatch.sv
// Read side of the start-token channel: a shift-register token store that feeds an
// ap_ctrl_hs start handshake into one PE and limits the number of in-flight invocations.
module linear_layer_start_token_dispatch #(
   parameter int unsigned DATA_WIDTH   = 1,
   parameter int unsigned ADDR_WIDTH   = 2,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   output logic                  pe_start,
   output logic [DATA_WIDTH-1:0] pe_token,
   input  logic                  pe_ready,
   input  logic                  pe_done,
   output logic [ADDR_WIDTH:0]   count,
   output logic [3:0]            inflight,
   output logic                  idle
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    MAX_C   = 4'(MAX_INFLIGHT);

   localparam logic [1:0] ST_EMPTY      = 2'd0;
   localparam logic [1:0] ST_READY_WAIT = 2'd1;
   localparam logic [1:0] ST_THROTTLED  = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [CW-1:0]         count_next;
   logic [3:0]            inflight_next;
   logic                  full_n_next;
   logic                  push;
   logic                  pop;
   logic                  done_ok;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign push    = if_write && if_full_n;
   assign pop     = pe_start && pe_ready;
   // A done pulse with nothing in flight is dropped rather than underflowing.
   assign done_ok = pe_done && (inflight != 4'd0);

   assign pe_start = (state == ST_READY_WAIT);
   assign idle     = (count == '0) && (inflight == 4'd0);
   assign rd_addr  = ADDR_WIDTH'(count - CW'(1));
   assign pe_token = (count == '0) ? '0 : mem[rd_addr];

   // Next-state and counter update; the state mirrors the post-update counters.
   always_comb begin
      count_next    = count;
      inflight_next = inflight;
      state_next    = state;
      full_n_next   = 1'b1;

      if (push && !pop && count != DEPTH_C)
         count_next = count + CW'(1);
      else if (pop && !push && count != '0)
         count_next = count - CW'(1);

      if (pop && !done_ok && inflight != 4'hF)
         inflight_next = inflight + 4'd1;
      else if (done_ok && !pop)
         inflight_next = inflight - 4'd1;

      case (state)
         ST_EMPTY, ST_READY_WAIT, ST_THROTTLED: begin
            if (count_next == '0)
               state_next = ST_EMPTY;
            else if (inflight_next >= MAX_C)
               state_next = ST_THROTTLED;
            else
               state_next = ST_READY_WAIT;
         end
         default: state_next = ST_EMPTY;
      endcase

      full_n_next = (count_next < DEPTH_C);
   end

   // Control registers; if_full_n stays low while reset is asserted.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= ST_EMPTY;
         count     <= '0;
         inflight  <= 4'd0;
         if_full_n <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         inflight  <= inflight_next;
         if_full_n <= full_n_next;
      end
   end

   // Token storage has no reset: entries behind count are never addressed.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[0] <= if_din;
         for (int i = 1; i < int'(DEPTH); i++)
            mem[i] <= mem[i-1];
      end
   end

endmodule
